// File: rtl/pwm_sequencer_if.sv
// Host-side bundle for pwm_sequencer: start/stop controls, table write port and status.
// The host drives the master modport; the sequencer implements the slave modport.
interface pwm_sequencer_if #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int DEPTH      = 8,
  parameter int REP_BITS   = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                  start;
  logic                  stop;
  logic [TIMER_BITS-1:0] prescale;
  logic [AW-1:0]         seq_last;
  logic                  loop;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [R:0]            cfg_duty;
  logic [REP_BITS-1:0]   cfg_reps;
  logic                  pwm_out;
  logic                  busy;
  logic [AW-1:0]         step_idx;
  logic                  done;

  modport master (
    output start, stop, prescale, seq_last, loop, cfg_we, cfg_addr, cfg_duty, cfg_reps,
    input  pwm_out, busy, step_idx, done
  );

  modport slave (
    input  start, stop, prescale, seq_last, loop, cfg_we, cfg_addr, cfg_duty, cfg_reps,
    output pwm_out, busy, step_idx, done
  );
endinterface

// File: rtl/pwm_sequencer.sv
// Sequences one PWM output through a table of duty-cycle steps, each held for a
// programmable number of PWM periods; runs once or loops, with graceful stop.
module pwm_sequencer #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int DEPTH      = 8,
  parameter int REP_BITS   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  pwm_sequencer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [R:0]          duty;
    logic [REP_BITS-1:0] reps;
  } entry_t;

  state_t                state;
  entry_t                table_q [DEPTH];
  logic [TIMER_BITS-1:0] prescale_l;
  logic [TIMER_BITS-1:0] presc_cnt;
  logic [AW-1:0]         seq_last_l;
  logic [AW-1:0]         step_idx;
  logic [R-1:0]          pwm_cnt;
  logic [R:0]            duty_cur;
  logic [REP_BITS-1:0]   reps_cur;
  logic [REP_BITS-1:0]   rep_cnt;
  logic                  done;

  logic                  tick;
  logic                  period_end;
  logic [AW-1:0]         next_idx;
  entry_t                next_entry;

  assign tick       = (state != IDLE) && (presc_cnt == prescale_l);
  assign period_end = tick && (pwm_cnt == '1);

  // After the last step the next index is 0, which is exactly the loop target.
  assign next_idx   = (step_idx == seq_last_l) ? '0 : step_idx + 1'b1;
  assign next_entry = table_q[next_idx];

  // Duty is one bit wider than the counter, so duty >= 2^R naturally yields constant high.
  assign bus.pwm_out  = (state != IDLE) && ({1'b0, pwm_cnt} < duty_cur);
  assign bus.busy     = (state != IDLE);
  assign bus.step_idx = step_idx;
  assign bus.done     = done;

  // NOTE: the table is reset explicitly because entries must read back as zero after reset;
  // an unreset memory would map to cheaper RAM but hold stale or X contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (bus.cfg_we) begin
      table_q[bus.cfg_addr] <= {bus.cfg_duty, bus.cfg_reps};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prescale_l <= '0;
      presc_cnt  <= '0;
      seq_last_l <= '0;
      step_idx   <= '0;
      pwm_cnt    <= '0;
      duty_cur   <= '0;
      reps_cur   <= '0;
      rep_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= RUN;
            prescale_l <= bus.prescale;
            seq_last_l <= bus.seq_last;
            duty_cur   <= table_q[0].duty;
            reps_cur   <= table_q[0].reps;
            presc_cnt  <= '0;
            pwm_cnt    <= '0;
            rep_cnt    <= '0;
            step_idx   <= '0;
          end
        end

        RUN, DRAIN: begin
          presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
          if (tick) pwm_cnt <= pwm_cnt + 1'b1;

          if (state == DRAIN) begin
            if (period_end) state <= IDLE;
          end else if (period_end) begin
            // A stop landing on the period boundary beats the step advance.
            if (bus.stop) begin
              state <= IDLE;
            end else if (rep_cnt != reps_cur) begin
              rep_cnt <= rep_cnt + 1'b1;
            end else begin
              rep_cnt <= '0;
              if ((step_idx != seq_last_l) || bus.loop) begin
                step_idx <= next_idx;
                duty_cur <= next_entry.duty;
                reps_cur <= next_entry.reps;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end else if (bus.stop) begin
            state <= DRAIN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: a clock-position reference model compared every
// cycle, directed scenarios with hand-computed expectations, then randomized runs.
module tb_pwm_sequencer;
  localparam int R          = 4;
  localparam int TIMER_BITS = 15;
  localparam int DEPTH      = 8;
  localparam int REP_BITS   = 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int STEPS      = 1 << R;

  logic clk;
  logic reset_n;

  pwm_sequencer_if #(.R(R), .TIMER_BITS(TIMER_BITS), .DEPTH(DEPTH), .REP_BITS(REP_BITS)) bus ();

  pwm_sequencer #(.R(R), .TIMER_BITS(TIMER_BITS), .DEPTH(DEPTH), .REP_BITS(REP_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: position within the current period in clocks, periods completed in
  // the current step, and the step's duty/length.
  int m_duty_tbl [DEPTH];
  int m_reps_tbl [DEPTH];
  bit m_busy = 0, m_drain = 0, m_done = 0;
  int m_pos = 0, m_rep = 0, m_step = 0, m_last = 0, m_pl = 1, m_duty = 0, m_reps = 0;

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_done = 0;
    m_pos = 0; m_rep = 0; m_step = 0; m_last = 0; m_pl = 1; m_duty = 0; m_reps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_duty_tbl[i] = 0;
      m_reps_tbl[i] = 0;
    end
  endtask

  task automatic model_load(input int idx);
    m_step = idx;
    m_duty = m_duty_tbl[idx];
    m_reps = m_reps_tbl[idx];
  endtask

  task automatic model_edge();
    bit pend;
    m_done = 0;
    if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1; m_drain = 0; m_pos = 0; m_rep = 0;
        m_pl   = int'(bus.prescale) + 1;
        m_last = int'(bus.seq_last);
        model_load(0);
      end
    end else begin
      pend  = (m_pos == STEPS * m_pl - 1);
      m_pos = pend ? 0 : m_pos + 1;
      if (pend) begin
        if (m_drain || bus.stop) m_busy = 0;
        else if (m_rep < m_reps) m_rep++;
        else begin
          m_rep = 0;
          if (m_step < m_last) model_load(m_step + 1);
          else if (bus.loop) model_load(0);
          else begin m_busy = 0; m_done = 1; end
        end
      end else if (bus.stop) m_drain = 1;
    end
    // Table writes land after this edge's load, which still sees the old contents.
    if (bus.cfg_we) begin
      m_duty_tbl[bus.cfg_addr] = int'(bus.cfg_duty);
      m_reps_tbl[bus.cfg_addr] = int'(bus.cfg_reps);
    end
  endtask

  function automatic bit model_pwm();
    int d;
    d = (m_duty > STEPS) ? STEPS : m_duty;
    return m_busy && (m_pos < d * m_pl);
  endfunction

  bit cmp_en = 1;

  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    if (cmp_en) begin
      check("pwm_out",  32'(bus.pwm_out),  32'(model_pwm()));
      check("busy",     32'(bus.busy),     32'(m_busy));
      check("step_idx", 32'(bus.step_idx), 32'(m_step));
      check("done",     32'(bus.done),     32'(m_done));
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_entry(input int addr, input int duty, input int reps);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_duty = (R + 1)'(duty);
    bus.cfg_reps = REP_BITS'(reps);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Returns at the negedge inside cycle 1 of the run.
  task automatic start_seq(input int presc, input int last, input bit lp);
    bus.prescale = TIMER_BITS'(presc);
    bus.seq_last = AW'(last);
    bus.loop     = lp;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Cycle numbers are 1-based from the call; 0 means the event was not seen.
  task automatic observe(input int n, output int hi, output int done_at,
                         output int idle_at, output int step1_at);
    hi = 0; done_at = 0; idle_at = 0; step1_at = 0;
    for (int c = 1; c <= n; c++) begin
      if (bus.pwm_out) hi++;
      if (bus.done && done_at == 0) done_at = c;
      if (!bus.busy && idle_at == 0) idle_at = c;
      if (bus.step_idx == AW'(1) && step1_at == 0) step1_at = c;
      @(negedge clk);
    end
  endtask

  int hi, done_at, idle_at, step1_at, cyc;

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.prescale = '0;
    bus.seq_last = '0;
    bus.loop     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_duty = '0;
    bus.cfg_reps = '0;
    tick_n(3);
    check("rst_pwm",  32'(bus.pwm_out),  0);
    check("rst_busy", 32'(bus.busy),     0);
    check("rst_step", 32'(bus.step_idx), 0);
    check("rst_done", 32'(bus.done),     0);
    reset_n = 1'b1;
    tick_n(2);

    // Single step, duty 4 of 16.
    write_entry(0, 4, 0);
    start_seq(0, 0, 0);
    observe(20, hi, done_at, idle_at, step1_at);
    check("t1_high", hi, 4);
    check("t1_done", done_at, 17);
    check("t1_idle", idle_at, 17);

    // Two steps: two periods at 8/16, then one constant-high period.
    write_entry(0, 8, 1);
    write_entry(1, 16, 0);
    start_seq(0, 1, 0);
    observe(52, hi, done_at, idle_at, step1_at);
    check("t2_high",  hi, 32);
    check("t2_step1", step1_at, 33);
    check("t2_done",  done_at, 49);

    // Prescaler and clamping.
    write_entry(0, 4, 0);
    start_seq(2, 0, 0);
    observe(52, hi, done_at, idle_at, step1_at);
    check("t3_high",  hi, 12);
    check("t3_done",  done_at, 49);
    write_entry(0, 0, 0);
    start_seq(2, 0, 0);
    observe(52, hi, done_at, idle_at, step1_at);
    check("t3_duty0", hi, 0);
    write_entry(0, 31, 0);
    start_seq(2, 0, 0);
    observe(52, hi, done_at, idle_at, step1_at);
    check("t3_duty31", hi, 48);

    // Loop over two steps, then drop loop during step 1.
    write_entry(0, 4, 0);
    write_entry(1, 8, 0);
    start_seq(0, 1, 1);
    check("t4_c1",  32'(bus.step_idx), 0);
    tick_n(16);
    check("t4_c17", 32'(bus.step_idx), 1);
    tick_n(16);
    check("t4_c33", 32'(bus.step_idx), 0);
    tick_n(16);
    check("t4_c49", 32'(bus.step_idx), 1);
    bus.loop = 1'b0;
    observe(24, hi, done_at, idle_at, step1_at);
    check("t4_done", done_at, 17);
    check("t4_high", hi, 8);

    // Stop mid-period: the period completes, no done.
    write_entry(0, 4, 3);
    start_seq(0, 0, 0);
    tick_n(4);
    bus.stop = 1'b1;
    tick_n(1);
    bus.stop = 1'b0;
    observe(15, hi, done_at, idle_at, step1_at);
    check("t5_idle", idle_at, 12);
    check("t5_done", done_at, 0);
    // Stop on the period boundary: straight to IDLE.
    start_seq(0, 0, 0);
    tick_n(15);
    bus.stop = 1'b1;
    tick_n(1);
    bus.stop = 1'b0;
    check("t5_pe_busy", 32'(bus.busy), 0);
    check("t5_pe_done", 32'(bus.done), 0);

    // Asynchronous reset mid-period while on step 1.
    write_entry(0, 8, 0);
    write_entry(1, 8, 0);
    start_seq(0, 1, 0);
    tick_n(18);
    check("t6_pre_step", 32'(bus.step_idx), 1);
    check("t6_pre_pwm",  32'(bus.pwm_out),  1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_pwm",  32'(bus.pwm_out),  0);
    check("t6_rst_busy", 32'(bus.busy),     0);
    check("t6_rst_step", 32'(bus.step_idx), 0);
    tick_n(2);
    reset_n = 1'b1;
    tick_n(1);
    start_seq(0, 0, 0);
    observe(20, hi, done_at, idle_at, step1_at);
    check("t6_tbl_high", hi, 0);
    check("t6_tbl_done", done_at, 17);

    // Shadowing: rewriting the active entry only affects the next load.
    write_entry(0, 4, 1);
    start_seq(0, 0, 0);
    write_entry(0, 12, 1);
    observe(40, hi, done_at, idle_at, step1_at);
    check("t6_shadow_high", hi, 7);
    check("t6_shadow_done", done_at, 32);
    start_seq(0, 0, 0);
    observe(40, hi, done_at, idle_at, step1_at);
    check("t6_new_high", hi, 24);
    check("t6_new_done", done_at, 33);

    // Randomized runs against the model.
    for (int run = 0; run < 30; run++) begin
      for (int k = 0; k < 4; k++)
        write_entry(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 2)));
      start_seq(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cyc = 0;
      while (bus.busy && cyc < 800) begin
        bus.cfg_we   = ($urandom_range(0, 7) == 0);
        bus.cfg_addr = AW'($urandom_range(0, DEPTH - 1));
        bus.cfg_duty = (R + 1)'($urandom_range(0, 31));
        bus.cfg_reps = REP_BITS'($urandom_range(0, 2));
        bus.stop     = ($urandom_range(0, 299) == 0);
        bus.start    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 199) == 0) bus.loop = ~bus.loop;
        @(negedge clk);
        cyc++;
      end
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      bus.stop   = 1'b1;
      cyc = 0;
      while (bus.busy && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      bus.stop = 1'b0;
      check("rand_drain_bound", 32'(bus.busy), 0);
      tick_n(2);
    end

    cmp_en = 0;
    tick_n(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Drives one PWM output through a programmable table of duty-cycle steps.
- Each step is held for a programmable number of PWM periods. The sequence either runs once or loops.
- Contains its own prescaler tick timer and PWM period counter. It is the controller that sequences timer/PWM hardware for LED fades, motor ramps and similar.
- Host side is a simple register-write table port plus start/stop controls.

Parameters:
- R, 8: duty resolution; PWM period = 2^R ticks.
- TIMER_BITS, 15: prescaler width.
- DEPTH, 8: number of table entries (power of 2).
- REP_BITS, 8: per-step repeat-count width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled in IDLE only.
- stop  in  1  graceful abort request.
- prescale  in  TIMER_BITS  tick every prescale+1 clocks; latched at start.
- seq_last  in  log2(DEPTH)  index of last step; latched at start.
- loop  in  1  restart at step 0 after last step; sampled live.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(DEPTH)  table entry index.
- cfg_duty  in  R+1  duty in ticks, 0..2^R.
- cfg_reps  in  REP_BITS  step length minus 1, in PWM periods.
- pwm_out  out  1  PWM waveform.
- busy  out  1  high in RUN or DRAIN.
- step_idx  out  log2(DEPTH)  active step.
- done  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset:
  - state IDLE; all counters, table entries, duty_cur, reps_cur and step_idx = 0.
  - pwm_out = 0, busy = 0, done = 0.
  - Takes effect immediately, including mid-operation.
- Table:
  - cfg_we writes {cfg_duty, cfg_reps} to entry cfg_addr on any cycle.
  - The active step uses shadow copies duty_cur/reps_cur, so a write to the active entry takes effect only the next time that step loads.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on the edge sampling start=1. On that edge:
  - latch prescale and seq_last;
  - load entry 0 into duty_cur/reps_cur;
  - clear presc_cnt, pwm_cnt, rep_cnt; step_idx = 0.
  - stop is ignored in IDLE; start and stop together starts normally.
- Tick generation:
  - presc_cnt counts 0..prescale_l; tick = (presc_cnt == prescale_l), then presc_cnt wraps to 0.
  - prescale = 0 gives a tick every cycle.
  - Counting happens only in RUN/DRAIN.
- PWM counter:
  - pwm_cnt (R bits) increments on tick and wraps 2^R-1 -> 0.
  - period_end = tick && pwm_cnt == 2^R-1.
- Output:
  - pwm_out = busy && (pwm_cnt < duty_cur).
  - duty 0 gives constant 0; duty >= 2^R gives constant 1 (values above 2^R clamp).
  - pwm_out goes high in the first cycle after the start edge when duty_cur > 0.
  - Period = 2^R*(prescale+1) clocks.
- Step advance, at period_end in RUN:
  - If rep_cnt != reps_cur: rep_cnt++.
  - Else rep_cnt = 0 and:
    - step_idx < seq_last: step_idx++ and load that entry (combinational table read, no gap cycle).
    - step_idx == seq_last and loop = 1: step_idx = 0, load entry 0.
    - step_idx == seq_last and loop = 0: go IDLE and pulse done for one cycle.
- Stop:
  - stop=1 in RUN -> DRAIN; the current period completes, then at period_end go IDLE.
  - No done pulse on a stopped run.
  - stop coinciding with period_end in RUN goes directly to IDLE; stop wins over step advance; no done.
  - start during RUN/DRAIN is ignored.
- busy falls on the same edge done rises; step_idx holds its last value in IDLE until the next start.

Test Plan:
1. Single step. R=4, prescale=0; entry0 duty=4, reps=0; seq_last=0, loop=0; pulse start -> pwm_out high cycles 1-4, low 5-16; done pulse at cycle 16; busy low afterward.
2. Two steps. entry0 duty=8, reps=1; entry1 duty=16, reps=0; seq_last=1 -> two periods at 8/16 high, one period constant high; step_idx 0->1 at cycle 32; done at cycle 48.
3. Prescaler and clamping. prescale=2, duty=4 -> high 12 clocks, low 36 (period 48). Repeat with duty=0 -> never high; duty=31 -> constant high.
4. Loop. loop=1, seq_last=1 -> step_idx follows 0,1,0,1; deassert loop during step 1 -> finishes step 1, done, IDLE, no further toggling.
5. Stop. Stop at cycle 5 of a period -> waveform continues to cycle 16, then IDLE, busy=0, no done. Stop exactly at period_end -> IDLE next edge, no done.
6. Reset and shadowing. Assert reset_n=0 mid-period -> pwm_out, busy, step_idx 0 immediately; table reads 0 after release. Write the active entry mid-step -> current step unchanged, new duty appears on the next load.
